// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_converter
// Description : Sequential double-dabble converter from unsigned binary to four
//               BCD digits, saturating at 9999 with an overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_converter #(
    parameter int IN_WIDTH  = 16,
    parameter int MAX_VALUE = 9999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] bin_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                busy,
    output logic                out_valid,
    output logic                overflow,
    output logic [3:0]          bcd_0,
    output logic [3:0]          bcd_1,
    output logic [3:0]          bcd_2,
    output logic [3:0]          bcd_3
);

    localparam int                  c_SHREG_W  = 14;
    localparam logic [IN_WIDTH-1:0] c_MAX_IN   = IN_WIDTH'(MAX_VALUE);
    localparam logic [13:0]         c_MAX_SR   = 14'(MAX_VALUE);
    localparam logic [3:0]          c_LAST_CNT = 4'(c_SHREG_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [13:0] r_shreg;
    logic [15:0] r_scratch;
    logic [3:0]  r_cnt;
    logic        r_ovf_pending;
    logic [15:0] r_bcd;
    logic        r_overflow;
    logic        r_out_valid;

    logic        w_sat;
    logic [13:0] w_sat_val;
    logic [15:0] w_adj;
    logic        w_accept;

    // Saturation is decided on the full input width, so upper bits never leak in.
    assign w_sat     = (bin_in > c_MAX_IN);
    assign w_sat_val = w_sat ? c_MAX_SR : bin_in[13:0];
    assign w_accept  = (r_state == ST_IDLE) && in_valid && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                                    ? (r_scratch[gi*4 +: 4] + 4'd3)
                                    : r_scratch[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg       <= '0;
            r_scratch     <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
            r_bcd         <= '0;
            r_overflow    <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg       <= w_sat_val;
                        r_ovf_pending <= w_sat;
                        r_scratch     <= '0;
                        r_cnt         <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Adjust then shift: the shreg MSB enters the scratch LSB.
                    r_scratch <= {w_adj[14:0], r_shreg[13]};
                    r_shreg   <= {r_shreg[12:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                end
                ST_DONE: begin
                    r_bcd       <= r_scratch;
                    r_overflow  <= r_ovf_pending;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !reset;
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign bcd_0     = r_bcd[3:0];
    assign bcd_1     = r_bcd[7:4];
    assign bcd_2     = r_bcd[11:8];
    assign bcd_3     = r_bcd[15:12];

endmodule
`default_nettype wire
